// File: rtl/vx_wb_arbiter.sv
// Shares one writeback port among NUM_REQS execute streams: round-robin with aging, sop..eop packet lock.
// One registered output stage (fire -> valid_out next cycle); ready_in only to the granted unit when the output can accept.
module vx_wb_arbiter #(
  parameter int  NUM_REQS  = 4,
  parameter int  DATAW     = 64,
  parameter int  AGE_LIMIT = 15,
  parameter int  CTR_BITS  = 32,
  localparam int SEL_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS-1:0]       sop_in,
  input  logic [NUM_REQS-1:0]       eop_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic                      sop_out,
  output logic                      eop_out,
  output logic [DATAW-1:0]          data_out,
  output logic [SEL_BITS-1:0]       sel_out,
  input  logic                      ready_out,
  output logic                      lock_active,
  output logic [CTR_BITS-1:0]       perf_conflicts
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state;
  logic [SEL_BITS-1:0] rr_ptr;
  logic [SEL_BITS-1:0] lock_idx;
  logic [SEL_BITS-1:0] grant_idx;
  logic [SEL_BITS-1:0] next_ptr;
  logic [SEL_BITS:0]   scan_idx;
  logic                grant_vld;
  logic                accept;
  logic                fire;
  logic [NUM_REQS-1:0] urgent;
  logic [NUM_REQS-1:0] fire_vec;
  logic [7:0]          age [NUM_REQS];

  assign accept   = ~valid_out | ready_out;
  assign fire     = accept & grant_vld;
  assign fire_vec = valid_in & ready_in;
  assign next_ptr = (grant_idx == SEL_BITS'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    urgent = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      urgent[i] = valid_in[i] && (age[i] == 8'(AGE_LIMIT));
    end
  end

  // Urgent requesters beat round-robin, but never break an open packet.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (state == LOCKED) begin
      grant_idx = lock_idx;
      grant_vld = valid_in[lock_idx];
    end else if (|urgent) begin
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
        if (urgent[i]) grant_idx = SEL_BITS'(i);
      end
      grant_vld = 1'b1;
    end else begin
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        scan_idx = {1'b0, rr_ptr} + (SEL_BITS+1)'(k);
        if (scan_idx >= (SEL_BITS+1)'(NUM_REQS)) scan_idx = scan_idx - (SEL_BITS+1)'(NUM_REQS);
        if (valid_in[scan_idx[SEL_BITS-1:0]]) begin
          grant_idx = scan_idx[SEL_BITS-1:0];
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ready_in = '0;
    if (fire) ready_in[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lock_active <= 1'b0;
      lock_idx    <= '0;
      rr_ptr      <= '0;
      valid_out   <= 1'b0;
      sop_out     <= 1'b0;
      eop_out     <= 1'b0;
      data_out    <= '0;
      sel_out     <= '0;
    end else begin
      if (fire) begin
        valid_out <= 1'b1;
        sop_out   <= sop_in[grant_idx];
        eop_out   <= eop_in[grant_idx];
        data_out  <= data_in[int'(grant_idx)*DATAW +: DATAW];
        sel_out   <= grant_idx;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
      // In LOCKED grant_idx equals lock_idx, so next_ptr covers both exits.
      if (fire) begin
        if (eop_in[grant_idx]) begin
          state       <= IDLE;
          lock_active <= 1'b0;
          rr_ptr      <= next_ptr;
        end else if (state == IDLE) begin
          state       <= LOCKED;
          lock_active <= 1'b1;
          lock_idx    <= grant_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_conflicts <= '0;
      for (int i = 0; i < NUM_REQS; i++) age[i] <= '0;
    end else begin
      if (fire && ($countones(valid_in) > 1)) perf_conflicts <= perf_conflicts + 1'b1;
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!valid_in[i] || fire_vec[i]) age[i] <= '0;
        else if (age[i] != 8'(AGE_LIMIT)) age[i] <= age[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Directed table-driven bench for vx_wb_arbiter (4-requester, AGE_LIMIT=4) plus a 1-requester instance.
module tb_vx_wb_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]  valid_in, sop_in, eop_in, ready_in;
  logic [63:0] data_in;
  logic        valid_out, sop_out, eop_out, ready_out, lock_active;
  logic [15:0] data_out;
  logic [1:0]  sel_out;
  logic [31:0] perf_conflicts;

  logic [0:0]  s_valid_in, s_sop_in, s_eop_in, s_ready_in;
  logic [15:0] s_data_in, s_data_out;
  logic        s_valid_out, s_sop_out, s_eop_out, s_ready_out, s_lock_active;
  logic [0:0]  s_sel_out;
  logic [31:0] s_perf;

  vx_wb_arbiter #(.NUM_REQS(4), .DATAW(16), .AGE_LIMIT(4), .CTR_BITS(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .sop_in(sop_in), .eop_in(eop_in),
    .data_in(data_in), .ready_in(ready_in), .valid_out(valid_out), .sop_out(sop_out),
    .eop_out(eop_out), .data_out(data_out), .sel_out(sel_out), .ready_out(ready_out),
    .lock_active(lock_active), .perf_conflicts(perf_conflicts)
  );

  vx_wb_arbiter #(.NUM_REQS(1), .DATAW(16), .AGE_LIMIT(4), .CTR_BITS(32)) dut1 (
    .clk(clk), .reset(reset), .valid_in(s_valid_in), .sop_in(s_sop_in), .eop_in(s_eop_in),
    .data_in(s_data_in), .ready_in(s_ready_in), .valid_out(s_valid_out), .sop_out(s_sop_out),
    .eop_out(s_eop_out), .data_out(s_data_out), .sel_out(s_sel_out), .ready_out(s_ready_out),
    .lock_active(s_lock_active), .perf_conflicts(s_perf)
  );

  typedef struct {
    logic [3:0] v, s, e;
    logic       ro;
    logic [3:0] x_rdy;
    logic       x_vo;
    logic [1:0] x_sel;
    logic       x_sop, x_eop, x_lock;
    logic [7:0] x_tag, x_perf;
  } vec_t;

  localparam int NV = 27;
  vec_t       tbl [NV];
  logic [7:0] lane_tag [4];
  logic [3:0] prev_v, prev_rdy;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic build_data();
    for (int i = 0; i < 4; i++) data_in[i*16 +: 16] = {4'hD, 2'b00, 2'(i), lane_tag[i]};
  endtask

  initial begin
    //          v        s        e        ro    rdy      vo    sel   sop   eop   lock  tag     perf
    tbl[0]  = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0,  8'd1};
    tbl[1]  = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 8'd0,  8'd2};
    tbl[2]  = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 8'd0,  8'd3};
    tbl[3]  = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 8'd0,  8'd4};
    tbl[4]  = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'd1,  8'd5};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd1,  8'd5};
    // req1 3-beat packet while req0/req2 wait
    tbl[6]  = '{4'b0111, 4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 8'd6,  8'd6};
    tbl[7]  = '{4'b0111, 4'b0101, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd7,  8'd7};
    tbl[8]  = '{4'b0111, 4'b0101, 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 8'd8,  8'd8};
    tbl[9]  = '{4'b0101, 4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 8'd6,  8'd9};
    tbl[10] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'd6,  8'd9};
    // 5-cycle output stall, then the saturated-age requesters win by lowest index
    for (int k = 11; k <= 15; k++)
      tbl[k] = '{4'b0111, 4'b0111, 4'b0111, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'd6, 8'd9};
    tbl[16] = '{4'b0111, 4'b0111, 4'b0111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'd11, 8'd10};
    tbl[17] = '{4'b0110, 4'b0110, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 8'd11, 8'd11};
    tbl[18] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 8'd11, 8'd11};
    // req3 5-beat packet; req2 goes urgent but must wait for eop
    tbl[19] = '{4'b1100, 4'b1100, 4'b0100, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 8'd19, 8'd12};
    tbl[20] = '{4'b1100, 4'b0100, 4'b0100, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 8'd20, 8'd13};
    tbl[21] = '{4'b1100, 4'b0100, 4'b0100, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 8'd21, 8'd14};
    tbl[22] = '{4'b1100, 4'b0100, 4'b0100, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 8'd22, 8'd15};
    tbl[23] = '{4'b1101, 4'b0101, 4'b1101, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 8'd23, 8'd16};
    tbl[24] = '{4'b0101, 4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 8'd19, 8'd17};
    tbl[25] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'd23, 8'd17};
    tbl[26] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd23, 8'd17};

    reset = 1'b1;
    valid_in = '0; sop_in = '0; eop_in = '0; data_in = '0; ready_out = 1'b1;
    s_valid_in = '0; s_sop_in = '0; s_eop_in = '0; s_data_in = '0; s_ready_out = 1'b1;
    for (int i = 0; i < 4; i++) lane_tag[i] = '0;
    prev_v = '0; prev_rdy = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_out", 64'(valid_out), 64'd0);
    chk("reset sop_eop", 64'({sop_out, eop_out}), 64'd0);
    chk("reset data_out", 64'(data_out), 64'd0);
    chk("reset sel_out", 64'(sel_out), 64'd0);
    chk("reset lock_active", 64'(lock_active), 64'd0);
    chk("reset perf", 64'(perf_conflicts), 64'd0);
    reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      // A waiting requester holds its payload; others present this step's tag.
      for (int i = 0; i < 4; i++)
        if (!(prev_v[i] && !prev_rdy[i])) lane_tag[i] = 8'(k);
      valid_in = tbl[k].v; sop_in = tbl[k].s; eop_in = tbl[k].e; ready_out = tbl[k].ro;
      build_data();
      #1;
      chk($sformatf("v%0d ready_in", k), 64'(ready_in), 64'(tbl[k].x_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid_out", k), 64'(valid_out), 64'(tbl[k].x_vo));
      chk($sformatf("v%0d sel_out", k), 64'(sel_out), 64'(tbl[k].x_sel));
      chk($sformatf("v%0d sop_out", k), 64'(sop_out), 64'(tbl[k].x_sop));
      chk($sformatf("v%0d eop_out", k), 64'(eop_out), 64'(tbl[k].x_eop));
      chk($sformatf("v%0d lock_active", k), 64'(lock_active), 64'(tbl[k].x_lock));
      chk($sformatf("v%0d data_out", k), 64'(data_out), 64'({4'hD, 2'b00, tbl[k].x_sel, tbl[k].x_tag}));
      chk($sformatf("v%0d perf", k), 64'(perf_conflicts), 64'(tbl[k].x_perf));
      prev_v = tbl[k].v; prev_rdy = tbl[k].x_rdy;
    end

    // Reset while req1's packet is open: lock and output beat dropped immediately.
    valid_in = 4'b0010; sop_in = 4'b0010; eop_in = 4'b0000; ready_out = 1'b1;
    #1;
    chk("lockrst ready_in", 64'(ready_in), 64'b0010);
    @(posedge clk);
    #1;
    chk("lockrst lock before", 64'(lock_active), 64'd1);
    chk("lockrst sel before", 64'(sel_out), 64'd1);
    reset = 1'b1;
    #1;
    chk("lockrst valid_out async", 64'(valid_out), 64'd0);
    chk("lockrst lock async", 64'(lock_active), 64'd0);
    chk("lockrst perf async", 64'(perf_conflicts), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    valid_in = 4'b1111; sop_in = 4'b1111; eop_in = 4'b1111;
    #1;
    chk("postrst ready_in", 64'(ready_in), 64'b0001);
    @(posedge clk);
    #1;
    chk("postrst sel_out", 64'(sel_out), 64'd0);
    chk("postrst valid_out", 64'(valid_out), 64'd1);
    chk("postrst perf", 64'(perf_conflicts), 64'd1);
    valid_in = '0;

    // Single-requester build: 2-beat packet with ready_out 1,0,1.
    s_valid_in = 1'b1; s_sop_in = 1'b1; s_eop_in = 1'b0; s_data_in = 16'hA001; s_ready_out = 1'b1;
    #1;
    chk("n1 s0 ready_in", 64'(s_ready_in), 64'd1);
    @(posedge clk);
    #1;
    chk("n1 s0 data", 64'({s_valid_out, s_sop_out, s_eop_out, s_data_out}), 64'({3'b110, 16'hA001}));
    chk("n1 s0 lock", 64'(s_lock_active), 64'd1);
    s_sop_in = 1'b0; s_eop_in = 1'b1; s_data_in = 16'hA002; s_ready_out = 1'b0;
    #1;
    chk("n1 s1 ready_in", 64'(s_ready_in), 64'd0);
    @(posedge clk);
    #1;
    chk("n1 s1 hold", 64'({s_valid_out, s_sop_out, s_eop_out, s_data_out}), 64'({3'b110, 16'hA001}));
    s_ready_out = 1'b1;
    #1;
    chk("n1 s2 ready_in", 64'(s_ready_in), 64'd1);
    @(posedge clk);
    #1;
    chk("n1 s2 data", 64'({s_valid_out, s_sop_out, s_eop_out, s_data_out}), 64'({3'b101, 16'hA002}));
    chk("n1 s2 lock", 64'(s_lock_active), 64'd0);
    chk("n1 s2 sel_perf", 64'({s_sel_out, s_perf}), 64'd0);
    s_valid_in = 1'b0;
    @(posedge clk);
    #1;
    chk("n1 s3 drained", 64'(s_valid_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
